// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_ILLEGAL_OP_EN: reserved op_codes respond with rsp_err=1 and zero data/flags.
module alu_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [OP_W-1:0]   alu_op_code,
   output logic [DATA_W-1:0] alu_rsa,
   output logic [DATA_W-1:0] alu_rsb,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [3:0]        alu_flags,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_flags,
   output logic              rsp_err
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t            state_q;
   logic              last_grant_q;
   logic              owner_q;
   logic              exec_cap_q;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] rsa_q;
   logic [DATA_W-1:0] rsb_q;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [3:0]        rsp_flags_q;
   logic              grant0;
   logic              grant1;
   logic              owner_ready;

   // On a tie the port not granted last wins.
   always_comb begin
      grant0      = req0_valid & (~req1_valid | last_grant_q);
      grant1      = req1_valid & (~req0_valid | ~last_grant_q);
      owner_ready = owner_q ? rsp1_ready : rsp0_ready;
   end

   assign req0_ready  = ~reset & (state_q == StIdle) & grant0;
   assign req1_ready  = ~reset & (state_q == StIdle) & grant1;
   assign alu_op_code = op_q;
   assign alu_rsa     = rsa_q;
   assign alu_rsb     = rsb_q;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_flags   = rsp_flags_q;

`ifdef ALU_ARB_ILLEGAL_OP_EN
   logic rsp_err_q;
   logic illegal_op;

   always_comb begin
      illegal_op = op_q inside {OP_W'(2), OP_W'(3), OP_W'(13), OP_W'(14), OP_W'(15)};
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         exec_cap_q   <= 1'b0;
         op_q         <= '0;
         rsa_q        <= '0;
         rsb_q        <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp_data_q   <= '0;
         rsp_flags_q  <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0) begin
                  op_q         <= req0_op;
                  rsa_q        <= req0_a;
                  rsb_q        <= req0_b;
                  owner_q      <= 1'b0;
                  last_grant_q <= 1'b0;
                  exec_cap_q   <= 1'b0;
                  state_q      <= StExec;
               end else if (grant1) begin
                  op_q         <= req1_op;
                  rsa_q        <= req1_a;
                  rsb_q        <= req1_b;
                  owner_q      <= 1'b1;
                  last_grant_q <= 1'b1;
                  exec_cap_q   <= 1'b0;
                  state_q      <= StExec;
               end
            end
            StExec: begin
               // First EXEC cycle lets the ALU settle; result is captured on the second edge.
               if (!exec_cap_q) begin
                  exec_cap_q <= 1'b1;
               end else begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                  rsp_data_q  <= illegal_op ? '0 : alu_out;
                  rsp_flags_q <= illegal_op ? '0 : alu_flags;
                  rsp_err_q   <= illegal_op;
`else
                  rsp_data_q  <= alu_out;
                  rsp_flags_q <= alu_flags;
`endif
                  rsp0_valid_q <= ~owner_q;
                  rsp1_valid_q <= owner_q;
                  state_q      <= StResp;
               end
            end
            StResp: begin
               if (owner_ready) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
